// File: rtl/pulse_meter.sv
// pulse_meter: synchronizes an asynchronous pulse train and measures the high and low
// durations of each full period (reported as duration minus 1) over a valid/ready handshake.
module pulse_meter #(
    parameter int unsigned CNT_BITS    = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_pulse,
    input  logic                i_ready,
    input  logic                i_clr_lost,
    output logic                o_valid,
    output logic [CNT_BITS-1:0] o_tiks_up,
    output logic [CNT_BITS-1:0] o_tiks_down,
    output logic                o_sat_up,
    output logic                o_sat_down,
    output logic                o_lost,
    output logic                o_level
);

    typedef enum logic [1:0] {StIdle, StPrime, StHigh, StLow} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level, rise, fall;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                   cnt_max;
    logic [CNT_BITS-1:0]    r_up_q, r_up_d;
    logic                   r_sat_up_q, r_sat_up_d;
    logic                   sat_h_q, sat_h_d;
    logic                   sat_l_q, sat_l_d;
    logic                   publish, load, drop, accept;

    assign level   = sync_q[SYNC_STAGES-1];
    assign rise    = level & ~prev_q;
    assign fall    = ~level & prev_q;
    assign o_level = level;

    // Saturating increment: the counter parks at all-ones once it is full.
    assign cnt_max = &cnt_q;
    assign cnt_inc = cnt_max ? cnt_q : cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Synchronizer chain and one-cycle delayed level for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pulse};
            prev_q <= level;
        end
    end

    // Measurement FSM next-state: priming edges, then alternate high/low counting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_up_d     = r_up_q;
        r_sat_up_d = r_sat_up_q;
        sat_h_d    = sat_h_q;
        sat_l_d    = sat_l_q;
        publish    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A high already in progress at reset release is never measured.
                if (fall) state_d = StPrime;
            end
            StPrime: begin
                if (rise) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    sat_h_d = 1'b0;
                end
            end
            StHigh: begin
                if (fall) begin
                    r_up_d     = cnt_q;
                    r_sat_up_d = sat_h_q;
                    cnt_d      = '0;
                    sat_l_d    = 1'b0;
                    state_d    = StLow;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_max) sat_h_d = 1'b1;
                end
            end
            StLow: begin
                if (rise) begin
                    publish = 1'b1;
                    cnt_d   = '0;
                    sat_h_d = 1'b0;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_max) sat_l_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and measurement registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            r_up_q     <= '0;
            r_sat_up_q <= 1'b0;
            sat_h_q    <= 1'b0;
            sat_l_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_up_q     <= r_up_d;
            r_sat_up_q <= r_sat_up_d;
            sat_h_q    <= sat_h_d;
            sat_l_q    <= sat_l_d;
        end
    end

    // A new period may overwrite the output slot only if the slot is empty or being taken.
    assign accept = o_valid & i_ready;
    assign load   = publish & (~o_valid | i_ready);
    assign drop   = publish & o_valid & ~i_ready;

    // Output slot and sticky lost flag; a drop beats a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid     <= 1'b0;
            o_tiks_up   <= '0;
            o_tiks_down <= '0;
            o_sat_up    <= 1'b0;
            o_sat_down  <= 1'b0;
            o_lost      <= 1'b0;
        end else begin
            if (load) begin
                o_valid     <= 1'b1;
                o_tiks_up   <= r_up_q;
                o_tiks_down <= cnt_q;
                o_sat_up    <= r_sat_up_q;
                o_sat_down  <= sat_l_q;
            end else if (accept) begin
                o_valid <= 1'b0;
            end
            if (drop) begin
                o_lost <= 1'b1;
            end else if (i_clr_lost) begin
                o_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: drives run-length pulse trains and compares pulse_meter against a
// run-length/handshake reference model every cycle, plus literal checks of key reports.
module tb_pulse_meter;

    localparam int unsigned CNT_BITS    = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam longint      MAXV        = (64'd1 << CNT_BITS) - 1;

    logic                i_clk = 1'b0;
    logic                i_reset_n = 1'b0;
    logic                i_pulse = 1'b0;
    logic                i_ready = 1'b0;
    logic                i_clr_lost = 1'b0;
    logic                o_valid;
    logic [CNT_BITS-1:0] o_tiks_up;
    logic [CNT_BITS-1:0] o_tiks_down;
    logic                o_sat_up;
    logic                o_sat_down;
    logic                o_lost;
    logic                o_level;

    pulse_meter #(
        .CNT_BITS   (CNT_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_pulse    (i_pulse),
        .i_ready    (i_ready),
        .i_clr_lost (i_clr_lost),
        .o_valid    (o_valid),
        .o_tiks_up  (o_tiks_up),
        .o_tiks_down(o_tiks_down),
        .o_sat_up   (o_sat_up),
        .o_sat_down (o_sat_down),
        .o_lost     (o_lost),
        .o_level    (o_level)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [CNT_BITS-1:0] up;
        logic [CNT_BITS-1:0] dn;
        logic                su;
        logic                sd;
    } rep_t;
    rep_t rep_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rep(input string name, input int idx, input logic [CNT_BITS-1:0] up,
                             input logic [CNT_BITS-1:0] dn, input logic su, input logic sd);
        rep_t req;
        req = '{up: up, dn: dn, su: su, sd: sd};
        checks++;
        if (idx < 0 || idx >= rep_q.size()) begin
            failures++;
            $display("FAIL %s report %0d missing, count=%0d", name, idx, rep_q.size());
        end else if (rep_q[idx] !== req) begin
            failures++;
            $display("FAIL %s actual up=%0h dn=%0h su=%0b sd=%0b required up=%0h dn=%0h su=%0b sd=%0b",
                     name, rep_q[idx].up, rep_q[idx].dn, rep_q[idx].su, rep_q[idx].sd,
                     up, dn, su, sd);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, 64'(o_valid), 64'd0);
        chk({name, "_up"}, 64'(o_tiks_up), 64'd0);
        chk({name, "_down"}, 64'(o_tiks_down), 64'd0);
        chk({name, "_sat"}, 64'({o_sat_up, o_sat_down}), 64'd0);
        chk({name, "_lost"}, 64'(o_lost), 64'd0);
        chk({name, "_level"}, 64'(o_level), 64'd0);
    endtask

    // ---------------- Reference model ----------------
    // Level seen by the meter is the input delayed through the synchronizer; periods are
    // formed from completed run lengths once a fall and then a rise have been observed.
    logic   smp[$];
    longint run_len, h_len;
    logic   seen_fall, in_high, h_valid;
    logic   e_valid, e_sat_up, e_sat_down, e_lost, e_level;
    logic [CNT_BITS-1:0] e_up, e_down;

    function automatic logic [CNT_BITS-1:0] tiks(input longint n);
        return (n - 1 > MAXV) ? CNT_BITS'(MAXV) : CNT_BITS'(n - 1);
    endfunction

    task automatic model_reset();
        smp = {};
        for (int i = 0; i <= SYNC_STAGES; i++) smp.push_back(1'b0);
        run_len = 0; h_len = 0;
        seen_fall = 0; in_high = 0; h_valid = 0;
        e_valid = 0; e_up = '0; e_down = '0; e_sat_up = 0; e_sat_down = 0;
        e_lost = 0; e_level = 0;
    endtask

    task automatic model_step();
        logic lv, pv, publish, drop;
        longint done_len;
        logic [CNT_BITS-1:0] p_up, p_dn;
        logic p_su, p_sd;
        lv = smp[$-(SYNC_STAGES-1)];
        pv = smp[$-SYNC_STAGES];
        publish = 0; drop = 0; done_len = 0;
        p_up = '0; p_dn = '0; p_su = 0; p_sd = 0;
        if (lv == pv) begin
            run_len++;
        end else begin
            done_len = run_len;
            run_len  = 1;
            if (!lv) begin
                if (in_high) begin
                    h_len   = done_len;
                    h_valid = 1;
                end
                seen_fall = 1;
            end else begin
                if (h_valid) begin
                    publish = 1;
                    p_up = tiks(h_len);    p_su = (h_len - 1 > MAXV);
                    p_dn = tiks(done_len); p_sd = (done_len - 1 > MAXV);
                end
                if (seen_fall) in_high = 1;
            end
        end
        if (publish) begin
            if (!e_valid || i_ready) begin
                e_valid = 1; e_up = p_up; e_down = p_dn; e_sat_up = p_su; e_sat_down = p_sd;
            end else begin
                drop = 1;
            end
        end else if (e_valid && i_ready) begin
            e_valid = 0;
        end
        if (drop) e_lost = 1;
        else if (i_clr_lost) e_lost = 0;
        smp.push_back(i_pulse);
        void'(smp.pop_front());
        e_level = smp[$-(SYNC_STAGES-1)];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison and capture of accepted reports.
    initial begin
        forever begin
            @(negedge i_clk);
            chk("valid", 64'(o_valid), 64'(e_valid));
            chk("tiks_up", 64'(o_tiks_up), 64'(e_up));
            chk("tiks_down", 64'(o_tiks_down), 64'(e_down));
            chk("sat_up", 64'(o_sat_up), 64'(e_sat_up));
            chk("sat_down", 64'(o_sat_down), 64'(e_sat_down));
            chk("lost", 64'(o_lost), 64'(e_lost));
            chk("level", 64'(o_level), 64'(e_level));
            if (o_valid && i_ready)
                rep_q.push_back('{up: o_tiks_up, dn: o_tiks_down, su: o_sat_up, sd: o_sat_down});
        end
    end

    // ---------------- Stimulus ----------------
    logic cur_lvl = 1'b0;
    logic rand_mode = 1'b0;

    task automatic seg(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            i_pulse = lvl;
            cur_lvl = lvl;
            if (rand_mode) begin
                i_ready    = ($urandom_range(0, 3) != 0);
                i_clr_lost = ($urandom_range(0, 15) == 0);
            end
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic settle(input int n);
        seg(cur_lvl, n);
    endtask

    initial begin
        int len;
        logic lvl;
        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_zero("reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Symmetric 256/256 with a discarded leading high
        i_ready = 1'b1;
        rep_q = {};
        seg(1, 50); seg(0, 256);
        seg(1, 256); seg(0, 256); seg(1, 256); seg(0, 256); seg(1, 5);
        settle(5);
        chk("sym_count", 64'(rep_q.size()), 64'd2);
        check_rep("sym_first", 0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check_rep("sym_last", rep_q.size() - 1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        chk("sym_lost", 64'(o_lost), 64'd0);

        // Minimum period, then 3/5
        rep_q = {};
        repeat (20) begin seg(0, 1); seg(1, 1); end
        seg(0, 1); seg(1, 3); seg(0, 5); seg(1, 3); seg(0, 5); seg(1, 3);
        settle(5);
        chk("minp_count", 64'(rep_q.size()), 64'd23);
        check_rep("minp_first", 0, 8'd9, 8'd0, 1'b0, 1'b0);
        check_rep("minp_1x1", 1, 8'd0, 8'd0, 1'b0, 1'b0);
        check_rep("minp_3x5", rep_q.size() - 1, 8'd2, 8'd4, 1'b0, 1'b0);
        chk("minp_lost", 64'(o_lost), 64'd0);

        // Saturation of the high counter, then recovery
        rep_q = {};
        seg(0, 10); seg(1, 300); seg(0, 10); seg(1, 5); seg(0, 5); seg(1, 5);
        settle(5);
        chk("sat_count", 64'(rep_q.size()), 64'd3);
        check_rep("sat_period", 1, 8'hFF, 8'd9, 1'b1, 1'b0);
        check_rep("sat_recover", 2, 8'd4, 8'd4, 1'b0, 1'b0);

        // Backpressure: first period held, second dropped
        seg(0, 5); seg(1, 10);
        i_ready = 1'b0;
        seg(0, 20); seg(1, 30); seg(0, 40); seg(1, 5);
        settle(5);
        chk("bp_valid", 64'(o_valid), 64'd1);
        chk("bp_up", 64'(o_tiks_up), 64'd9);
        chk("bp_down", 64'(o_tiks_down), 64'd19);
        chk("bp_lost", 64'(o_lost), 64'd1);
        i_ready = 1'b1;
        settle(1);
        i_ready = 1'b0;
        chk("bp_drop_valid", 64'(o_valid), 64'd0);
        chk("bp_lost_held", 64'(o_lost), 64'd1);
        i_clr_lost = 1'b1;
        settle(1);
        i_clr_lost = 1'b0;
        chk("bp_clr_lost", 64'(o_lost), 64'd0);

        // Reset while high; input still high at release
        i_ready = 1'b1;
        settle(3);
        #1;
        i_reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        rep_q = {};
        seg(1, 5); seg(0, 10); seg(1, 10); seg(0, 10); seg(1, 10);
        settle(5);
        chk("rst_count", 64'(rep_q.size()), 64'd1);
        check_rep("rst_first", 0, 8'd9, 8'd9, 1'b0, 1'b0);

        // Randomized run lengths, ready and clear
        rand_mode = 1'b1;
        lvl = 1'b0;
        for (int s = 0; s < 300; s++) begin
            case ($urandom_range(0, 15))
                0:       len = $urandom_range(255, 300);
                1:       len = $urandom_range(254, 258);
                default: len = $urandom_range(1, 12);
            endcase
            seg(lvl, len);
            lvl = ~lvl;
        end
        rand_mode = 1'b0;
        i_ready = 1'b1;
        i_clr_lost = 1'b0;
        settle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Receive-side counterpart of the board's pulse generator. Takes an asynchronous pulse train from a PMOD pin, synchronizes it to `i_clk`, and measures the high and low durations of every full period in clock ticks. It reports each period over a valid/ready handshake. Durations use the generator's limit encoding, where a level held N cycles is reported as N-1, so a looped-back generator set to limit L reads back L.

## Interface
- `CNT_BITS`, default 64: width of the duration counters and reported values.
- `SYNC_STAGES`, default 2: flip-flops in the input synchronizer, minimum 2.

Ports, clock and reset first:
- `i_clk`  in  1  sole clock.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_pulse`  in  1  asynchronous pulse input.
- `i_ready`  in  1  consumer accepts the current measurement.
- `i_clr_lost`  in  1  clears `o_lost`.
- `o_valid`  out  1  measurement available.
- `o_tiks_up`  out  CNT_BITS  high duration minus 1.
- `o_tiks_down`  out  CNT_BITS  low duration minus 1.
- `o_sat_up`  out  1  high counter saturated during this period.
- `o_sat_down`  out  1  low counter saturated during this period.
- `o_lost`  out  1  sticky flag: a completed period was dropped.
- `o_level`  out  1  synchronized input level.

## Operation
**Input path**
- Synchronizer chain `s` is `SYNC_STAGES` flops; `o_level` is the last stage.
- `prev` is `o_level` delayed one cycle.
- Rise = `o_level & ~prev`. Fall = `~o_level & prev`.

**States**
- IDLE: on fall, go to PRIME. Any partial period present at reset release is discarded.
- PRIME: on rise, go to HIGH with `cnt <= 0`. No counting in this state.
- HIGH
  - Each cycle without fall: `cnt <= cnt+1`, saturating at all-ones; set `sat_h` when the counter would wrap.
  - On fall: `r_up <= cnt`, `r_sat_up <= sat_h`, `cnt <= 0`, clear `sat_l`, go to LOW.
- LOW
  - Each cycle without rise: saturating increment, setting `sat_l` when the counter would wrap.
  - On rise: publish `{r_up, cnt, r_sat_up, sat_l}`, then `cnt <= 0`, clear `sat_h`, go to HIGH.

**Arithmetic**
- Level lasting N synchronized cycles reports `min(N-1, 2^CNT_BITS-1)`.
- The sat flag is set only if N-1 exceeds `2^CNT_BITS-1`.
- N=1 reports 0; 1-cycle pulses are legal.

**Publish and handshake**
- Publish loads the outputs and sets `o_valid` when `o_valid==0`, or when `o_valid & i_ready` in the same cycle.
- Otherwise the new period is dropped, `o_lost <= 1`, and the outputs are unchanged.
- `o_valid & i_ready` with no publish in that cycle: `o_valid <= 0`.
- While `o_valid & ~i_ready`, all data outputs hold stable.
- `i_clr_lost` clears `o_lost`. A drop in the same cycle wins, so `o_lost` stays 1.
- `i_ready` while `o_valid==0` has no effect.

**Reset**
- Asserting `i_reset_n` low, at any time, immediately clears:
  - the synchronizer, `prev`, `cnt`, all registers and all outputs;
  - the state, which returns to IDLE.
- An in-flight period is lost and not reported.
- After release, the first report needs a fall, then rise, fall and rise.

## Timing
- Reset values:
  - `o_valid`, `o_tiks_up`, `o_tiks_down`, `o_sat_up`, `o_sat_down`, `o_lost`, `o_level` are all 0;
  - the state is IDLE.
- Input edge to rise/fall detection: `SYNC_STAGES` to `SYNC_STAGES+1` cycles of jitter. Both edges see the same pipeline, so durations are exact for synchronous sources and ±1 for asynchronous ones.
- Detection of the closing rise to `o_valid` high: 1 cycle, registered.
- Sustained throughput: one measurement per period, provided `i_ready` is asserted within 2 cycles (the minimum period) of `o_valid`.
- No combinational path from inputs to outputs.

## Test plan
- **Looped-back generator, symmetric:** high 256 and low 256 cycles repeating, `i_ready=1` → after the priming edges, each period reports `o_tiks_up=0xFF` and `o_tiks_down=0xFF`, sat flags 0, `o_lost=0`.
- **Minimum period:** alternating 1 high / 1 low, `i_ready=1` → `o_valid` on every second cycle with values 0/0. Then 3 high / 5 low → values 2/4.
- **Saturation, `CNT_BITS=8`:** high 300, low 10 → `o_tiks_up=0xFF`, `o_sat_up=1`, `o_tiks_down=9`, `o_sat_down=0`. The next period, 5/5, reports 4/4 with both flags 0.
- **Backpressure:** `i_ready=0` over two periods, 10/20 then 30/40 → first values 9/19 held, `o_lost=1`. Then `i_ready=1` for one cycle → `o_valid` drops. Then `i_clr_lost` → `o_lost=0`.
- **Reset mid-HIGH:** pull `i_reset_n` low 3 cycles while the input is high → all outputs 0 immediately. The input finishing high and then going 10 low / 10 high / 10 low produces no report until the first full 10/10 period after priming → 9/9.
- **Startup discard:** input already high at reset release → the first report reflects the first complete period after the first fall, never the partial initial high.
